// File: rtl/nf10_timestamp_pkg.sv
// Shared defaults and framing-state encoding for the nf10_timestamp pcore.
// Imported by the timestamp inserter, its stream interface and testbench.
package nf10_timestamp_pkg;

  localparam int TIMESTAMP_WIDTH_DEF = 64;
  localparam int TS_POS_DEF          = 64;
  localparam int C_DATA_WIDTH_DEF    = 256;
  localparam int C_USER_WIDTH_DEF    = 128;

  typedef enum logic {
    ST_SOF = 1'b0,
    ST_MID = 1'b1
  } frame_state_t;

endpackage

// File: rtl/timestamp_inserter_if.sv
// AXI4-Stream bundle used on both sides of the timestamp inserter.
// The master modport drives payload and valid; the slave modport drives ready.
interface timestamp_inserter_if
  import nf10_timestamp_pkg::*;
#(
  parameter int DATA_W = C_DATA_WIDTH_DEF,
  parameter int USER_W = C_USER_WIDTH_DEF
);
  localparam int KEEP_W = DATA_W / 8;

  logic [DATA_W-1:0] tdata;
  logic [KEEP_W-1:0] tkeep;
  logic [USER_W-1:0] tuser;
  logic              tlast;
  logic              tvalid;
  logic              tready;

  modport master (
    output tdata, tkeep, tuser, tlast, tvalid,
    input  tready
  );

  modport slave (
    input  tdata, tkeep, tuser, tlast, tvalid,
    output tready
  );

endinterface

// File: rtl/axis_skid_buffer.sv
// Two-entry register slice: an output register plus one spare entry.
// Upstream ready is registered and equals "spare entry empty".
module axis_skid_buffer #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [WIDTH-1:0] i_data,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [WIDTH-1:0] o_data
);

  logic             r_out_valid;
  logic             r_spare_valid;
  logic             r_ready;
  logic [WIDTH-1:0] r_out_data;
  logic [WIDTH-1:0] r_spare_data;

  logic w_accept;
  logic w_out_free;
  logic w_spare_valid_next;

  assign w_accept   = i_valid & r_ready;
  assign w_out_free = ~r_out_valid | i_ready;

  // The spare only fills when the output register is held by back-pressure.
  always_comb begin
    w_spare_valid_next = r_spare_valid;
    if (w_out_free) begin
      w_spare_valid_next = 1'b0;
    end else if (w_accept) begin
      w_spare_valid_next = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid   <= 1'b0;
      r_spare_valid <= 1'b0;
      r_ready       <= 1'b0;
      // NOTE: payload registers are reset as well so the master bus reads 0 during reset.
      r_out_data    <= '0;
      r_spare_data  <= '0;
    end else begin
      r_ready       <= ~w_spare_valid_next;
      r_spare_valid <= w_spare_valid_next;
      if (w_out_free) begin
        if (r_spare_valid) begin
          r_out_valid <= 1'b1;
          r_out_data  <= r_spare_data;
        end else begin
          r_out_valid <= w_accept;
          if (w_accept) begin
            r_out_data <= i_data;
          end
        end
      end else if (w_accept) begin
        r_spare_data <= i_data;
      end
    end
  end

  assign o_ready = r_ready;
  assign o_valid = r_out_valid;
  assign o_data  = r_out_data;

endmodule

// File: rtl/timestamp_inserter.sv
// Inline AXI4-Stream stage that writes the stamp seen at first presentation of
// each packet's first beat into a fixed tuser field, counting stamped packets.
module timestamp_inserter
  import nf10_timestamp_pkg::*;
#(
  parameter int TIMESTAMP_WIDTH = TIMESTAMP_WIDTH_DEF,
  parameter int C_DATA_WIDTH    = C_DATA_WIDTH_DEF,
  parameter int C_USER_WIDTH    = C_USER_WIDTH_DEF,
  parameter int TS_POS          = TS_POS_DEF
) (
  input  logic                       axi_aclk,
  input  logic                       axi_resetn,
  input  logic [TIMESTAMP_WIDTH-1:0] stamp_counter,
  input  logic                       timestamp_en,
  timestamp_inserter_if.slave        s_axis,
  timestamp_inserter_if.master       m_axis,
  output logic [31:0]                stamped_pkts
);

  localparam int KEEP_W = C_DATA_WIDTH / 8;
  localparam int BEAT_W = C_DATA_WIDTH + KEEP_W + C_USER_WIDTH + 1;

  if (TS_POS + TIMESTAMP_WIDTH > C_USER_WIDTH) begin : g_bad_field
    $error("stamp field does not fit inside tuser");
  end

  frame_state_t r_state;
  frame_state_t w_state_next;

  logic [TIMESTAMP_WIDTH-1:0] r_ts_hold;
  logic                       r_ts_held;
  logic [31:0]                r_stamped_pkts;

  logic                       w_s_ready;
  logic                       w_accept;
  logic                       w_is_sof;
  logic                       w_insert;
  logic [TIMESTAMP_WIDTH-1:0] w_stamp;
  logic [C_USER_WIDTH-1:0]    w_user;
  logic [BEAT_W-1:0]          w_in_beat;
  logic [BEAT_W-1:0]          w_out_beat;
  logic                       w_m_valid;

  assign w_accept = s_axis.tvalid & w_s_ready;

  always_ff @(posedge axi_aclk or negedge axi_resetn) begin
    if (!axi_resetn) begin
      r_state <= ST_SOF;
    end else begin
      // NOTE: sequential state uses <= so every flop samples pre-edge values.
      r_state <= w_state_next;
    end
  end

  always_comb begin
    // NOTE: every combinational output gets a default first, so no path infers a latch.
    w_state_next = r_state;
    w_is_sof     = (r_state == ST_SOF);
    if (w_accept) begin
      w_state_next = s_axis.tlast ? ST_SOF : ST_MID;
    end
  end

  // A stamp held from an earlier stalled presentation wins over the live value.
  always_comb begin
    w_stamp  = r_ts_held ? r_ts_hold : stamp_counter;
    w_insert = w_accept & w_is_sof & timestamp_en;
    w_user   = s_axis.tuser;
    if (w_insert) begin
      w_user[TS_POS +: TIMESTAMP_WIDTH] = w_stamp;
    end
  end

  always_ff @(posedge axi_aclk or negedge axi_resetn) begin
    if (!axi_resetn) begin
      r_ts_hold      <= '0;
      r_ts_held      <= 1'b0;
      r_stamped_pkts <= '0;
    end else begin
      if (w_is_sof && s_axis.tvalid && !w_accept && !r_ts_held) begin
        r_ts_hold <= stamp_counter;
        r_ts_held <= 1'b1;
      end else if (w_is_sof && w_accept) begin
        r_ts_held <= 1'b0;
      end
      if (w_insert) begin
        r_stamped_pkts <= r_stamped_pkts + 32'd1;
      end
    end
  end

  assign w_in_beat = {s_axis.tdata, s_axis.tkeep, w_user, s_axis.tlast};

  axis_skid_buffer #(
    .WIDTH (BEAT_W)
  ) u_skid (
    .clk     (axi_aclk),
    .rst_n   (axi_resetn),
    .i_valid (s_axis.tvalid),
    .o_ready (w_s_ready),
    .i_data  (w_in_beat),
    .o_valid (w_m_valid),
    .i_ready (m_axis.tready),
    .o_data  (w_out_beat)
  );

  assign s_axis.tready = w_s_ready;
  assign m_axis.tvalid = w_m_valid;
  assign {m_axis.tdata, m_axis.tkeep, m_axis.tuser, m_axis.tlast} = w_out_beat;
  assign stamped_pkts  = r_stamped_pkts;

endmodule

// File: tb/tb_timestamp_inserter.sv
// Self-checking bench for timestamp_inserter: directed scenarios plus a random
// stream compared against a packet-level reference model.
module tb_timestamp_inserter;
  import nf10_timestamp_pkg::*;

  localparam int TSW = 64;
  localparam int DW  = 256;
  localparam int KW  = DW / 8;
  localparam int UW  = 128;
  localparam int TSP = 64;

  typedef struct packed {
    logic [DW-1:0] data;
    logic [KW-1:0] keep;
    logic [UW-1:0] user;
    logic          last;
  } beat_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Stamp source: base value advancing 0x20 per cycle while running.
  logic [63:0] stamp_base = 64'h0;
  int unsigned cyc_base   = 0;
  bit          stamp_run  = 1'b0;
  logic [63:0] stamp_counter;
  assign stamp_counter = stamp_run ? stamp_base + 64'(cyc - cyc_base) * 64'h20 : stamp_base;

  logic        timestamp_en = 1'b1;
  logic [31:0] stamped_pkts;

  timestamp_inserter_if #(.DATA_W(DW), .USER_W(UW)) s_axis ();
  timestamp_inserter_if #(.DATA_W(DW), .USER_W(UW)) m_axis ();

  timestamp_inserter dut (
    .axi_aclk      (clk),
    .axi_resetn    (rst_n),
    .stamp_counter (stamp_counter),
    .timestamp_en  (timestamp_en),
    .s_axis        (s_axis),
    .m_axis        (m_axis),
    .stamped_pkts  (stamped_pkts)
  );

  beat_t       exp_q[$];
  beat_t       got_q[$];
  int          n_pass       = 0;
  int          n_total      = 0;
  int          exp_stamped  = 0;
  int unsigned ready_pct    = 100;

  function automatic logic [63:0] model_stamp();
    return stamp_run ? stamp_base + 64'(cyc - cyc_base) * 64'h20 : stamp_base;
  endfunction

  function automatic beat_t rand_beat();
    beat_t b;
    for (int i = 0; i < DW / 32; i++) b.data[32*i +: 32] = $urandom;
    b.keep = $urandom;
    for (int i = 0; i < UW / 32; i++) b.user[32*i +: 32] = $urandom;
    b.last = 1'b0;
    return b;
  endfunction

  // Output monitor: scoreboard compare, stall stability, and m_axis_tready drive.
  initial begin
    beat_t cur;
    beat_t prev;
    beat_t want;
    bit    stall_prev;
    stall_prev    = 1'b0;
    prev          = '0;
    m_axis.tready = 1'b1;
    forever begin
      @(negedge clk);
      cur = {m_axis.tdata, m_axis.tkeep, m_axis.tuser, m_axis.tlast};
      if (!rst_n) begin
        stall_prev = 1'b0;
      end else begin
        if (stall_prev) begin
          n_total++;
          if (m_axis.tvalid !== 1'b1 || cur !== prev)
            $display("FAIL stall_hold: valid=%b user=%h, required valid=1 user=%h (held)",
                     m_axis.tvalid, cur.user, prev.user);
          else n_pass++;
        end
        if (m_axis.tvalid === 1'b1 && m_axis.tready === 1'b1) begin
          got_q.push_back(cur);
          n_total++;
          if (exp_q.size() == 0) begin
            $display("FAIL stream_beat: unexpected beat user=%h last=%b, required no beat",
                     cur.user, cur.last);
          end else begin
            want = exp_q.pop_front();
            if (cur !== want)
              $display("FAIL stream_beat: user=%h last=%b data=%h, required user=%h last=%b data=%h",
                       cur.user, cur.last, cur.data, want.user, want.last, want.data);
            else n_pass++;
          end
        end
        stall_prev = (m_axis.tvalid === 1'b1) && (m_axis.tready !== 1'b1);
        prev       = cur;
      end
      @(posedge clk);
      #1;
      m_axis.tready = (ready_pct >= 100) ? 1'b1 : ($urandom_range(99) < ready_pct);
    end
  end

  // Present one beat at the current negedge and hold it until accepted.
  task automatic send_beat(input beat_t b, input bit is_sof, input bit en);
    logic [63:0] pres_stamp;
    beat_t       want;
    int          waited;
    s_axis.tdata  = b.data;
    s_axis.tkeep  = b.keep;
    s_axis.tuser  = b.user;
    s_axis.tlast  = b.last;
    s_axis.tvalid = 1'b1;
    timestamp_en  = en;
    pres_stamp    = model_stamp();
    waited        = 0;
    while (s_axis.tready !== 1'b1 && waited < 1000) begin
      @(negedge clk);
      waited++;
    end
    if (s_axis.tready !== 1'b1) begin
      n_total++;
      $display("FAIL accept_timeout: tready=%b after %0d cycles, required 1", s_axis.tready, waited);
      s_axis.tvalid = 1'b0;
    end else begin
      want = b;
      if (is_sof && en) begin
        want.user[TSP +: TSW] = pres_stamp;
        exp_stamped++;
      end
      exp_q.push_back(want);
      @(negedge clk);
    end
  endtask

  task automatic send_pkt(input int len, input bit en_sof, input bit toggle_mid, input int unsigned gap_pct);
    beat_t b;
    for (int i = 0; i < len; i++) begin
      b      = rand_beat();
      b.last = (i == len - 1);
      while (gap_pct > 0 && $urandom_range(99) < gap_pct) begin
        s_axis.tvalid = 1'b0;
        @(negedge clk);
      end
      send_beat(b, i == 0, (i == 0) ? en_sof : (toggle_mid ? !en_sof : en_sof));
    end
    s_axis.tvalid = 1'b0;
  endtask

  task automatic drain();
    int waited = 0;
    s_axis.tvalid = 1'b0;
    ready_pct     = 100;
    while (exp_q.size() != 0 && waited < 3000) begin
      @(negedge clk);
      waited++;
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset();
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    n_total++; if (m_axis.tvalid !== 1'b0) $display("FAIL rst_m_tvalid: got %b, required 0", m_axis.tvalid); else n_pass++;
    n_total++; if (s_axis.tready !== 1'b0) $display("FAIL rst_s_tready: got %b, required 0", s_axis.tready); else n_pass++;
    n_total++; if (stamped_pkts !== 32'd0) $display("FAIL rst_stamped: got %0d, required 0", stamped_pkts); else n_pass++;
    n_total++; if (m_axis.tuser !== '0) $display("FAIL rst_tuser: got %h, required 0", m_axis.tuser); else n_pass++;
    rst_n = 1'b1;
    @(negedge clk);
    n_total++; if (s_axis.tready !== 1'b1) $display("FAIL rst_ready_rise: got %b, required 1", s_axis.tready); else n_pass++;
  endtask

  task automatic test_back_to_back();
    beat_t g;
    got_q.delete();
    stamp_base = 64'h100;
    cyc_base   = cyc;
    stamp_run  = 1'b1;
    send_pkt(3, 1'b1, 1'b0, 0);
    send_pkt(1, 1'b1, 1'b0, 0);
    drain();
    n_total++; if (exp_q.size() != 0) $display("FAIL b2b_drain: %0d beats missing, required 0", exp_q.size()); else n_pass++;
    n_total++; if (got_q.size() != 4) $display("FAIL b2b_count: got %0d beats, required 4", got_q.size()); else n_pass++;
    if (got_q.size() == 4) begin
      g = got_q[0];
      n_total++; if (g.user[TSP +: TSW] !== 64'h100) $display("FAIL b2b_stamp0: got %h, required %h", g.user[TSP +: TSW], 64'h100); else n_pass++;
      g = got_q[3];
      n_total++; if (g.user[TSP +: TSW] !== 64'h160) $display("FAIL b2b_stamp1: got %h, required %h", g.user[TSP +: TSW], 64'h160); else n_pass++;
    end
    n_total++; if (stamped_pkts !== 32'd2) $display("FAIL b2b_stamped: got %0d, required 2", stamped_pkts); else n_pass++;
  endtask

  task automatic test_sof_backpressure();
    beat_t g;
    got_q.delete();
    stamp_run  = 1'b0;
    stamp_base = 64'h40;
    ready_pct  = 0;
    repeat (2) @(negedge clk);
    send_pkt(1, 1'b1, 1'b0, 0);
    send_pkt(1, 1'b1, 1'b0, 0);
    stamp_base = 64'h1000;
    cyc_base   = cyc;
    stamp_run  = 1'b1;
    fork
      send_pkt(2, 1'b1, 1'b0, 0);
      begin
        repeat (5) @(negedge clk);
        n_total++; if (s_axis.tready !== 1'b0) $display("FAIL bp_ready_low: got %b, required 0", s_axis.tready); else n_pass++;
        ready_pct = 100;
      end
    join
    drain();
    n_total++; if (exp_q.size() != 0) $display("FAIL bp_drain: %0d beats missing, required 0", exp_q.size()); else n_pass++;
    n_total++; if (got_q.size() != 4) $display("FAIL bp_count: got %0d beats, required 4", got_q.size()); else n_pass++;
    if (got_q.size() == 4) begin
      g = got_q[2];
      n_total++; if (g.user[TSP +: TSW] !== 64'h1000) $display("FAIL bp_stamp: got %h, required %h", g.user[TSP +: TSW], 64'h1000); else n_pass++;
    end
    n_total++; if (stamped_pkts !== 32'(exp_stamped)) $display("FAIL bp_stamped: got %0d, required %0d", stamped_pkts, exp_stamped); else n_pass++;
  endtask

  task automatic test_ts_disable();
    beat_t       b;
    beat_t       g;
    logic [UW-1:0] dead;
    dead = {4{32'hDEADBEEF}};
    got_q.delete();
    stamp_run  = 1'b0;
    stamp_base = 64'h2000;
    b = rand_beat(); b.user = dead; b.last = 1'b0; send_beat(b, 1'b1, 1'b0);
    b = rand_beat(); b.user = dead; b.last = 1'b1; send_beat(b, 1'b0, 1'b1);
    drain();
    n_total++; if (stamped_pkts !== 32'(exp_stamped)) $display("FAIL dis_stamped: got %0d, required %0d", stamped_pkts, exp_stamped); else n_pass++;
    b = rand_beat(); b.user = dead; b.last = 1'b0; send_beat(b, 1'b1, 1'b1);
    b = rand_beat(); b.user = dead; b.last = 1'b1; send_beat(b, 1'b0, 1'b0);
    drain();
    n_total++; if (got_q.size() != 4) $display("FAIL dis_count: got %0d beats, required 4", got_q.size()); else n_pass++;
    if (got_q.size() == 4) begin
      g = got_q[0];
      n_total++; if (g.user !== dead) $display("FAIL dis_passthru: got %h, required %h", g.user, dead); else n_pass++;
      g = got_q[2];
      n_total++; if (g.user !== {64'h2000, dead[63:0]}) $display("FAIL dis_toggle_on: got %h, required %h", g.user, {64'h2000, dead[63:0]}); else n_pass++;
      g = got_q[3];
      n_total++; if (g.user !== dead) $display("FAIL dis_mid_beat: got %h, required %h", g.user, dead); else n_pass++;
    end
    n_total++; if (stamped_pkts !== 32'(exp_stamped)) $display("FAIL dis_stamped2: got %0d, required %0d", stamped_pkts, exp_stamped); else n_pass++;
  endtask

  task automatic test_wrap();
    beat_t g;
    got_q.delete();
    stamp_base = 64'hFFFF_FFFF_FFFF_FFE0;
    cyc_base   = cyc;
    stamp_run  = 1'b1;
    send_pkt(1, 1'b1, 1'b0, 0);
    send_pkt(2, 1'b1, 1'b0, 0);
    drain();
    n_total++; if (got_q.size() != 3) $display("FAIL wrap_count: got %0d beats, required 3", got_q.size()); else n_pass++;
    if (got_q.size() == 3) begin
      g = got_q[0];
      n_total++; if (g.user[TSP +: TSW] !== 64'hFFFF_FFFF_FFFF_FFE0) $display("FAIL wrap_top: got %h, required %h", g.user[TSP +: TSW], 64'hFFFF_FFFF_FFFF_FFE0); else n_pass++;
      g = got_q[1];
      n_total++; if (g.user[TSP +: TSW] !== 64'h0) $display("FAIL wrap_zero: got %h, required 0", g.user[TSP +: TSW]); else n_pass++;
    end
  endtask

  task automatic test_random();
    int total_beats = 0;
    int len;
    got_q.delete();
    stamp_base = 64'h5_0000;
    cyc_base   = cyc;
    stamp_run  = 1'b1;
    ready_pct  = 50;
    for (int p = 0; p < 1000; p++) begin
      len = $urandom_range(4, 1);
      total_beats += len;
      send_pkt(len, 1'($urandom_range(1)), 1'($urandom_range(1)), 25);
    end
    drain();
    n_total++; if (exp_q.size() != 0) $display("FAIL rnd_drain: %0d beats missing, required 0", exp_q.size()); else n_pass++;
    n_total++; if (got_q.size() != total_beats) $display("FAIL rnd_count: got %0d beats, required %0d", got_q.size(), total_beats); else n_pass++;
    n_total++; if (stamped_pkts !== 32'(exp_stamped)) $display("FAIL rnd_stamped: got %0d, required %0d", stamped_pkts, exp_stamped); else n_pass++;
  endtask

  task automatic test_reset_mid_packet();
    beat_t b;
    beat_t g;
    got_q.delete();
    ready_pct  = 100;
    stamp_run  = 1'b0;
    stamp_base = 64'h7700;
    repeat (2) @(negedge clk);
    b = rand_beat(); b.last = 1'b0; send_beat(b, 1'b1, 1'b1);
    b = rand_beat();
    s_axis.tdata  = b.data;
    s_axis.tkeep  = b.keep;
    s_axis.tuser  = b.user;
    s_axis.tlast  = 1'b0;
    s_axis.tvalid = 1'b1;
    #2 rst_n = 1'b0;
    @(negedge clk);
    n_total++; if (m_axis.tvalid !== 1'b0) $display("FAIL rmp_m_tvalid: got %b, required 0", m_axis.tvalid); else n_pass++;
    n_total++; if (s_axis.tready !== 1'b0) $display("FAIL rmp_s_tready: got %b, required 0", s_axis.tready); else n_pass++;
    n_total++; if (stamped_pkts !== 32'd0) $display("FAIL rmp_stamped: got %0d, required 0", stamped_pkts); else n_pass++;
    n_total++; if (m_axis.tdata !== '0) $display("FAIL rmp_tdata: got %h, required 0", m_axis.tdata); else n_pass++;
    s_axis.tvalid = 1'b0;
    exp_q.delete();
    exp_stamped = 0;
    rst_n = 1'b1;
    @(negedge clk);
    stamp_base = 64'h8800;
    b = rand_beat(); b.last = 1'b0; send_beat(b, 1'b1, 1'b1);
    b = rand_beat(); b.last = 1'b1; send_beat(b, 1'b0, 1'b1);
    drain();
    n_total++; if (got_q.size() != 3) $display("FAIL rmp_count: got %0d beats, required 3", got_q.size()); else n_pass++;
    if (got_q.size() == 3) begin
      g = got_q[1];
      n_total++; if (g.user[TSP +: TSW] !== 64'h8800) $display("FAIL rmp_sof_stamp: got %h, required %h", g.user[TSP +: TSW], 64'h8800); else n_pass++;
    end
    n_total++; if (stamped_pkts !== 32'd1) $display("FAIL rmp_stamped_after: got %0d, required 1", stamped_pkts); else n_pass++;
  endtask

  initial begin
    s_axis.tdata  = '0;
    s_axis.tkeep  = '0;
    s_axis.tuser  = '0;
    s_axis.tlast  = 1'b0;
    s_axis.tvalid = 1'b0;
    test_reset();
    test_back_to_back();
    test_sof_backpressure();
    test_ts_disable();
    test_wrap();
    test_random();
    test_reset_mid_packet();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
